// File: rtl/telephony_pkg.sv
// Shared telephony transport definitions: cmd encodings, packet constants, tx FSM states.
// TRANSPORT_CHECKSUM_EN adds the CHECKSUM state used by the trailing checksum byte.
package telephony_pkg;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;

  localparam logic [7:0] PKT_TYPE_CTRL  = 8'h01;
  localparam logic [7:0] PKT_TYPE_AUDIO = 8'h02;
  localparam logic [7:0] SYNC_BYTE      = 8'hA5;

  localparam int         HDR_LEN      = 6;
  localparam logic [7:0] HDR_LAST_IDX = 8'(HDR_LEN - 1);

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE    = 2'd0;
  localparam tx_state_t ST_HEADER  = 2'd1;
  localparam tx_state_t ST_PAYLOAD = 2'd2;
`ifdef TRANSPORT_CHECKSUM_EN
  localparam tx_state_t ST_CHECKSUM = 2'd3;
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/transport_fifo.sv
// Synchronous audio FIFO; exposes the head word and the word behind it so the
// framer can fetch the next sample in the same cycle the current one is popped.
module transport_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         rd_data_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_MAX);
  assign empty = (count_q == '0);
  assign count = count_q;

  assign rd_data      = mem_q[rd_ptr_q];
  assign rd_data_next = mem_q[rd_ptr_q + PTR_ONE];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/transport_tx.sv
// Transport-layer transmitter: frames control words and audio blocks into byte packets.
// Define TRANSPORT_CHECKSUM_EN to append a mod-256 checksum of B1..last payload byte.
module transport_tx
  import telephony_pkg::*;
#(
  parameter int         AUDIO_WORDS = 8,
  parameter int         FIFO_DEPTH  = 16,
  parameter logic [7:0] SRC_ADDR    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  cmd,
  input  logic [15:0] data_in,
  input  logic [7:0]  dest_addr,
  output logic        transport_busy,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic [7:0]  drop_count
);

  localparam int            CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] AUDIO_THRESH = CW'(AUDIO_WORDS);
  localparam logic [CW-1:0] BUSY_THRESH  = CW'(FIFO_DEPTH - 1);
  localparam logic [7:0]    AUDIO_LEN    = 8'(2 * AUDIO_WORDS);
  localparam logic [7:0]    CTRL_LEN     = 8'd2;
`ifdef TRANSPORT_CHECKSUM_EN
  localparam logic          CSUM_EN      = 1'b1;
`else
  localparam logic          CSUM_EN      = 1'b0;
`endif

  tx_state_t   state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic        is_audio_q, is_audio_d;
  logic [7:0]  dest_q, dest_d;
  logic [7:0]  seq_q, seq_d;
  logic        ctrl_pending_q, ctrl_pending_d;
  logic [15:0] ctrl_word_q, ctrl_word_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        tx_last_q, tx_last_d;
  logic [7:0]  drop_count_q, drop_count_d;
`ifdef TRANSPORT_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0]   fifo_rd_data, fifo_rd_data_next;
  logic [CW-1:0] fifo_count;

  logic          xfer, pkt_done, cmd_ctrl, cmd_audio;
  logic [7:0]    pkt_len, hdr_idx, hdr_byte, pay_idx, pay_byte;
  logic          pay_last;

  transport_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (fifo_push),
    .pop          (fifo_pop),
    .wr_data      (data_in),
    .rd_data      (fifo_rd_data),
    .rd_data_next (fifo_rd_data_next),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count)
  );

  // Link handshake: a byte moves when tx_valid && tx_ready at a clock edge; while
  // tx_valid is high and tx_ready low, tx_data/tx_valid/tx_last hold unchanged.
  assign xfer      = tx_valid_q && tx_ready;
  assign pkt_done  = xfer && tx_last_q;
  assign cmd_ctrl  = (cmd == CMD_CTRL);
  assign cmd_audio = (cmd == CMD_AUDIO);
  assign pkt_len   = is_audio_q ? AUDIO_LEN : CTRL_LEN;
  assign pay_last  = (idx_q == pkt_len - 8'd1);

  always_comb begin
    hdr_idx = idx_q + 8'd1;
    case (hdr_idx)
      8'd1:    hdr_byte = is_audio_q ? PKT_TYPE_AUDIO : PKT_TYPE_CTRL;
      8'd2:    hdr_byte = dest_q;
      8'd3:    hdr_byte = SRC_ADDR;
      8'd4:    hdr_byte = seq_q;
      default: hdr_byte = pkt_len;
    endcase
  end

  // Byte about to be loaded into the payload; an even index past zero follows a
  // popped low byte, so it comes from the word behind the current head.
  always_comb begin
    pay_idx = (state_q == ST_HEADER) ? 8'd0 : idx_q + 8'd1;
    if (!is_audio_q)          pay_byte = (pay_idx == 8'd0) ? ctrl_word_q[15:8] : ctrl_word_q[7:0];
    else if (pay_idx == 8'd0) pay_byte = fifo_rd_data[15:8];
    else if (pay_idx[0])      pay_byte = fifo_rd_data[7:0];
    else                      pay_byte = fifo_rd_data_next[15:8];
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    is_audio_d = is_audio_q;
    dest_d     = dest_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ctrl_pending_q || fifo_count >= AUDIO_THRESH) begin
          state_d    = ST_HEADER;
          idx_d      = 8'd0;
          is_audio_d = !ctrl_pending_q;
          dest_d     = ctrl_pending_q ? ctrl_word_q[15:8] : dest_addr;
          tx_data_d  = SYNC_BYTE;
          tx_valid_d = 1'b1;
          tx_last_d  = 1'b0;
        end
      end
      ST_HEADER: begin
        if (xfer) begin
          if (idx_q == HDR_LAST_IDX) begin
            state_d   = ST_PAYLOAD;
            idx_d     = 8'd0;
            tx_data_d = pay_byte;
            tx_last_d = !CSUM_EN && (pkt_len == 8'd1);
          end else begin
            idx_d     = hdr_idx;
            tx_data_d = hdr_byte;
          end
        end
      end
      ST_PAYLOAD: begin
        if (xfer) begin
          fifo_pop = is_audio_q && idx_q[0] && !fifo_empty;
          if (pay_last) begin
`ifdef TRANSPORT_CHECKSUM_EN
            state_d   = ST_CHECKSUM;
            tx_data_d = csum_q;
            tx_last_d = 1'b1;
`else
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
`endif
          end else begin
            idx_d     = pay_idx;
            tx_data_d = pay_byte;
            tx_last_d = !CSUM_EN && (pay_idx == pkt_len - 8'd1);
          end
        end
      end
`ifdef TRANSPORT_CHECKSUM_EN
      ST_CHECKSUM: begin
        if (xfer) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase
  end

`ifdef TRANSPORT_CHECKSUM_EN
  // Accumulate every byte loaded after B0 up to the last payload byte.
  always_comb begin
    csum_d = csum_q;
    if (state_q == ST_IDLE)
      csum_d = 8'd0;
    else if (xfer && (state_q == ST_HEADER || (state_q == ST_PAYLOAD && !pay_last)))
      csum_d = csum_q + tx_data_d;
  end
`endif

  always_comb begin
    ctrl_pending_d = ctrl_pending_q;
    ctrl_word_d    = ctrl_word_q;
    seq_d          = pkt_done ? seq_q + 8'd1 : seq_q;
    drop_count_d   = drop_count_q;
    fifo_push      = cmd_audio && !fifo_full;
    if (pkt_done && !is_audio_q) ctrl_pending_d = 1'b0;
    if (cmd_ctrl && !ctrl_pending_q) begin
      ctrl_pending_d = 1'b1;
      ctrl_word_d    = data_in;
    end
    if ((cmd_ctrl && ctrl_pending_q) || (cmd_audio && fifo_full))
      drop_count_d = sat_inc8(drop_count_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= 8'd0;
      is_audio_q     <= 1'b0;
      dest_q         <= 8'd0;
      seq_q          <= 8'd0;
      ctrl_pending_q <= 1'b0;
      ctrl_word_q    <= 16'd0;
      tx_data_q      <= 8'd0;
      tx_valid_q     <= 1'b0;
      tx_last_q      <= 1'b0;
      drop_count_q   <= 8'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      is_audio_q     <= is_audio_d;
      dest_q         <= dest_d;
      seq_q          <= seq_d;
      ctrl_pending_q <= ctrl_pending_d;
      ctrl_word_q    <= ctrl_word_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      tx_last_q      <= tx_last_d;
      drop_count_q   <= drop_count_d;
    end
  end

`ifdef TRANSPORT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) csum_q <= 8'd0;
    else       csum_q <= csum_d;
  end
`endif

  assign transport_busy = ctrl_pending_q || (fifo_count >= BUSY_THRESH);
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign tx_last        = tx_last_q;
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_transport_tx.sv
// Scoreboard bench for transport_tx: packets are built from the framing rules when
// stimulus is issued; a negedge monitor pops and compares every accepted link byte.
module tb_transport_tx;

  localparam int         AUDIO_WORDS = 8;
  localparam int         FIFO_DEPTH  = 16;
  localparam logic [7:0] SRC_ADDR    = 8'h00;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] data_in = 16'h0;
  logic [7:0]  dest_addr = 8'h0;
  logic        tx_ready = 1'b0;
  logic        transport_busy, tx_valid, tx_last;
  logic [7:0]  tx_data, drop_count;

  transport_tx #(
    .AUDIO_WORDS (AUDIO_WORDS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SRC_ADDR    (SRC_ADDR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd            (cmd),
    .data_in        (data_in),
    .dest_addr      (dest_addr),
    .transport_busy (transport_busy),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_last        (tx_last),
    .drop_count     (drop_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: {missing, last, byte}
  logic [9:0]  exp_q[$];
  logic [7:0]  pl_q[$];
  logic [15:0] aud_q[$];
  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  logic [7:0]  m_seq = 8'h00;
  logic [7:0]  m_drop = 8'h00;
  logic        mon_en = 1'b0;
  logic        ready_rand = 1'b0;
  logic        ready_fixed = 1'b0;
  logic        gap_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Build a whole frame from the layout rules and queue it.
  task automatic push_packet(input logic [7:0] ptype, input logic [7:0] dest);
    logic [7:0] b[$];
    logic [7:0] sum;
    b = {8'hA5, ptype, dest, SRC_ADDR, m_seq, 8'(pl_q.size())};
    foreach (pl_q[i]) b.push_back(pl_q[i]);
`ifdef TRANSPORT_CHECKSUM_EN
    sum = 8'h00;
    for (int i = 1; i < b.size(); i++) sum = sum + b[i];
    b.push_back(sum);
`endif
    foreach (b[i]) exp_q.push_back({1'b0, (i == b.size() - 1), b[i]});
    m_seq = m_seq + 8'd1;
  endtask

  task automatic send_ctrl(input logic [15:0] w, input bit dropped);
    cmd = 2'b01;
    data_in = w;
    tick;
    cmd = 2'b00;
    if (dropped) begin
      if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end else begin
      pl_q = {w[15:8], w[7:0]};
      push_packet(8'h01, w[15:8]);
    end
  endtask

  task automatic send_audio(input logic [15:0] w, input bit dropped);
    logic [15:0] x;
    cmd = 2'b10;
    data_in = w;
    tick;
    cmd = 2'b00;
    if (dropped) begin
      if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end else begin
      aud_q.push_back(w);
      if (aud_q.size() == AUDIO_WORDS) begin
        pl_q = {};
        repeat (AUDIO_WORDS) begin
          x = aud_q.pop_front();
          pl_q.push_back(x[15:8]);
          pl_q.push_back(x[7:0]);
        end
        push_packet(8'h02, dest_addr);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 3000) begin
      tick;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // link-side ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ready_rand ? ($urandom_range(0, 1) == 1) : ready_fixed;
    end
  end

  // monitor: compare accepted bytes, hold stability, and inter-packet gap
  initial begin
    logic       stalled;
    logic [8:0] held;
    logic [9:0] e;
    int         gap_state;
    logic       gap_seen;
    stalled = 1'b0;
    held = '0;
    gap_state = 0;
    gap_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        stalled = 1'b0;
        gap_state = 0;
      end else begin
        if (stalled) begin
          check("hold_valid", tx_valid, 1);
          check("hold_byte", {tx_last, tx_data}, held);
        end
        if (gap_state == 1) begin
          check("gap_idle", tx_valid, 0);
          gap_state = 2;
        end else if (gap_state == 2) begin
          check("gap_restart", {tx_valid, tx_data}, {1'b1, 8'hA5});
          gap_state = 0;
        end
        if (tx_valid && tx_ready) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
          check("link_byte", {1'b0, tx_last, tx_data}, e);
          acc_cnt++;
          if (gap_req && !gap_seen && tx_last) begin
            gap_state = 1;
            gap_seen = 1'b1;
          end
        end
        stalled = tx_valid && !tx_ready;
        held = {tx_last, tx_data};
      end
    end
  end

  initial begin
    int n;
    int base;

    // reset values
    repeat (3) tick;
    reset = 1'b0;
    check("rst_valid", tx_valid, 0);
    check("rst_last", tx_last, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", transport_busy, 0);
    check("rst_drop", drop_count, 0);
    mon_en = 1'b1;
    ready_fixed = 1'b1;
    tick;

    // control packet: latency and busy until the last byte goes
    send_ctrl(16'h2A01, 1'b0);
    check("lat_valid_n", tx_valid, 0);
    check("ctrl_busy", transport_busy, 1);
    tick;
    check("lat_valid_n1", {tx_valid, tx_data}, {1'b1, 8'hA5});
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      check("busy_during_ctrl", transport_busy, 1);
      tick;
      n++;
    end
    check("ctrl_drain", exp_q.size(), 0);
    check("busy_after_ctrl", transport_busy, 0);
    wait_drain("ctrl_done");

    // audio packet with ascending words
    dest_addr = 8'h2A;
    for (int k = 0; k < AUDIO_WORDS; k++) send_audio(16'(k), 1'b0);
    wait_drain("audio_seq");

    // audio packets under random backpressure
    ready_rand = 1'b1;
    for (int p = 0; p < 3; p++) begin
      dest_addr = 8'($urandom);
      for (int k = 0; k < AUDIO_WORDS; k++) send_audio(16'($urandom), 1'b0);
      wait_drain("audio_rand");
    end
    ready_rand = 1'b0;

    // FIFO overflow with the link stalled, then back-to-back release
    ready_fixed = 1'b0;
    tick;
    tick;
    for (int k = 0; k < 17; k++) begin
      send_audio(16'h0100 + 16'(k), k == 16);
      if (k == 13) check("busy_after_14", transport_busy, 0);
      if (k == 14) check("busy_after_15", transport_busy, 1);
    end
    check("drop_overflow", drop_count, m_drop);
    gap_req = 1'b1;
    ready_fixed = 1'b1;
    wait_drain("overflow_release");

    // control arriving mid-audio, second control dropped
    dest_addr = 8'h33;
    for (int k = 0; k < AUDIO_WORDS; k++) send_audio(16'hC000 + 16'(k), 1'b0);
    repeat (4) tick;
    send_ctrl(16'h4B07, 1'b0);
    send_ctrl(16'h5C09, 1'b1);
    check("drop_ctrl", drop_count, m_drop);
    wait_drain("ctrl_after_audio");

    // enough packets to wrap seq
    for (int p = 0; p < 256; p++) begin
      n = 0;
      while (transport_busy && n < 100) begin
        tick;
        n++;
      end
      check("busy_free", transport_busy, 0);
      send_ctrl(16'($urandom), 1'b0);
    end
    wait_drain("seq_wrap");
    check("drop_final", drop_count, m_drop);

    // reset in the middle of a payload
    base = acc_cnt;
    send_ctrl(16'h7E11, 1'b0);
    n = 0;
    while (acc_cnt < base + 7 && n < 100) begin
      tick;
      n++;
    end
    check("reached_payload", acc_cnt, base + 7);
    reset = 1'b1;
    tick;
    check("midrst_valid", tx_valid, 0);
    check("midrst_last", tx_last, 0);
    check("midrst_busy", transport_busy, 0);
    check("midrst_drop", drop_count, 0);
    exp_q.delete();
    aud_q.delete();
    m_seq = 8'h00;
    m_drop = 8'h00;
    reset = 1'b0;
    tick;
    send_ctrl(16'h1902, 1'b0);
    wait_drain("post_reset_seq0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
